// File: rtl/stream_arbiter.sv
// Round-robin, packet-locked N:1 stream arbiter feeding a single upsizer through
// a one-deep registered output stage; each beat carries the index of its source.
module stream_arbiter #(
  parameter int T_DATA_WIDTH = 32,
  parameter int T_SRC_COUNT  = 4,
  parameter int T_ID_WIDTH   = $clog2(T_SRC_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_SRC_COUNT],
  input  logic [T_SRC_COUNT-1:0]  s_last_i,
  input  logic [T_SRC_COUNT-1:0]  s_valid_i,
  output logic [T_SRC_COUNT-1:0]  s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic [T_ID_WIDTH-1:0]   m_id_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [T_ID_WIDTH-1:0]   grant_o,
  output logic                    busy_o,
  output logic                    dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [T_ID_WIDTH-1:0]   rr_ptr;
  logic [T_ID_WIDTH-1:0]   pick;
  logic                    slot_free;
  logic                    accept;
  logic                    accept_last;
  int                      idx;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and ready here never looks at any s_valid_i.
  assign slot_free   = !m_valid_o || m_ready_i;
  assign accept      = (state == LOCK) && slot_free && s_valid_i[grant_o];
  assign accept_last = accept && s_last_i[grant_o];

  assign busy_o      = (state == LOCK);
  assign dbg_state_o = logic'(state);

  // Search downwards so the requester closest to rr_ptr is the one that sticks.
  always_comb begin
    pick = rr_ptr;
    idx  = 0;
    for (int i = T_SRC_COUNT - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= T_SRC_COUNT) idx = idx - T_SRC_COUNT;
      if (s_valid_i[idx]) pick = T_ID_WIDTH'(idx);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|s_valid_i) state_nxt = LOCK;
      LOCK:    if (accept_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = '0;
    if (state == LOCK) s_ready_o[grant_o] = slot_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |s_valid_i) grant_o <= pick;
      if (accept_last) begin
        if (grant_o == T_ID_WIDTH'(T_SRC_COUNT - 1)) rr_ptr <= '0;
        else                                         rr_ptr <= grant_o + T_ID_WIDTH'(1);
      end
    end
  end

  // Output stage: a new beat may load in the same cycle the old one drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
      m_id_o    <= '0;
    end else if (accept) begin
      m_valid_o <= 1'b1;
      m_data_o  <= s_data_i[grant_o];
      m_last_o  <= s_last_i[grant_o];
      m_id_o    <= grant_o;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: reset, fairness, wrap-around, backpressure,
// mid-packet stall and single-beat packets through a small upsizer model.
module tb_stream_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int QW = IW + 1 + DW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_data_i [N];
  logic [N-1:0]  s_last_i;
  logic [N-1:0]  s_valid_i;
  logic [N-1:0]  s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic [IW-1:0] m_id_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [IW-1:0] grant_o;
  logic          busy_o;
  logic          dbg_state_o;

  int errors = 0;
  int checks = 0;

  int           beat_cnt [N];
  int           plen;
  logic [N-1:0] src_en;
  logic [QW-1:0] exp_q[$];

  stream_arbiter #(.T_DATA_WIDTH(DW), .T_SRC_COUNT(N), .T_ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_last_o(m_last_o), .m_id_o(m_id_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .grant_o(grant_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  function automatic logic [DW-1:0] beat_data(input int src, input int cnt);
    return {8'(src), 24'(cnt)};
  endfunction

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      s_valid_i[i] = src_en[i];
      s_data_i[i]  = beat_data(i, beat_cnt[i]);
      s_last_i[i]  = ((beat_cnt[i] % plen) == plen - 1);
    end
  endtask

  // One rising edge; sources whose beat was taken advance to the next beat.
  task automatic clock_sources();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = s_valid_i & s_ready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) beat_cnt[i]++;
    drive_sources();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    src_en = '0;
    m_ready_i = 1'b1;
    plen = 1;
    for (int i = 0; i < N; i++) beat_cnt[i] = 0;
    drive_sources();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    src_en = '0;
    m_ready_i = 1'b0;
    plen = 4;
    for (int i = 0; i < N; i++) beat_cnt[i] = 0;
    drive_sources();
    @(posedge clk);
    #1;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid_o); end
    checks++; if (m_data_o !== '0) begin errors++; $display("FAIL rst_m_data: got %h want 0", m_data_o); end
    checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b want 0", m_last_o); end
    checks++; if (m_id_o !== '0) begin errors++; $display("FAIL rst_m_id: got %0d want 0", m_id_o); end
    checks++; if (s_ready_o !== '0) begin errors++; $display("FAIL rst_s_ready: got %b want 0000", s_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (grant_o !== '0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_o); end
    rst = 1'b0;
    src_en = 4'b0010;
    drive_sources();
    clock_sources();
    clock_sources();
    checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", m_valid_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", m_valid_o); end
    checks++; if (s_ready_o !== '0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0000", s_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
    for (int i = 0; i < N; i++) beat_cnt[i] = 0;
    src_en = 4'b0100;
    m_ready_i = 1'b1;
    drive_sources();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b want 0", m_valid_o); end
    clock_sources();
    checks++; if (grant_o !== 2'd2) begin errors++; $display("FAIL rst_regrant: got %0d want 2", grant_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_regrant_busy: got %b want 1", busy_o); end
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int pk [N] = '{default: 0};
    int cyc = 0;
    logic prev_last = 1'b0;
    logic [QW-1:0] exp;
    logic [QW-1:0] got;
    apply_reset();
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < 2; b++)
        exp_q.push_back({IW'(order[k]), (b == 1), beat_data(order[k], pk[order[k]] * 2 + b)});
      pk[order[k]]++;
    end
    plen = 2;
    src_en = 4'b1111;
    drive_sources();
    while (exp_q.size() > 0 && cyc < 60) begin
      clock_sources();
      cyc++;
      if (prev_last) begin
        checks++;
        if (m_valid_o !== 1'b0) begin errors++; $display("FAIL fair_bubble: cycle %0d m_valid got %b want 0", cyc, m_valid_o); end
      end
      prev_last = 1'b0;
      if (m_valid_o === 1'b1) begin
        exp = exp_q.pop_front();
        got = {m_id_o, m_last_o, m_data_o};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL fair_beat: got id/last/data %h want %h", got, exp); end
        prev_last = m_last_o;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fair_timeout: %0d beats missing, want 0", exp_q.size()); end
  endtask

  task automatic test_wrap_skip();
    logic [IW-1:0] exp_g [3] = '{2'd3, 2'd1, 2'd3};
    int seen = 0;
    int cyc = 0;
    logic prev_busy = 1'b0;
    apply_reset();
    plen = 1;
    src_en = 4'b0010;
    drive_sources();
    clock_sources();
    clock_sources();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wrap_idle: busy got %b want 0", busy_o); end
    src_en = 4'b1010;
    drive_sources();
    while (seen < 3 && cyc < 30) begin
      clock_sources();
      cyc++;
      checks++;
      if ((s_ready_o[0] | s_ready_o[2]) !== 1'b0) begin errors++; $display("FAIL wrap_ready02: s_ready got %b want x0x0", s_ready_o); end
      if (busy_o && !prev_busy) begin
        checks++;
        if (grant_o !== exp_g[seen]) begin errors++; $display("FAIL wrap_grant: #%0d got %0d want %0d", seen, grant_o, exp_g[seen]); end
        seen++;
      end
      prev_busy = busy_o;
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL wrap_timeout: grants seen %0d want 3", seen); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a = beat_data(1, 0);
    logic [DW-1:0] b = beat_data(1, 1);
    logic [DW-1:0] c = beat_data(1, 2);
    apply_reset();
    plen = 3;
    src_en = 4'b0010;
    drive_sources();
    clock_sources();
    checks++; if (grant_o !== 2'd1 || busy_o !== 1'b1) begin errors++; $display("FAIL bp_grant: got %0d/%b want 1/1", grant_o, busy_o); end
    clock_sources();
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== a) begin errors++; $display("FAIL bp_first: got %b/%h want 1/%h", m_valid_o, m_data_o, a); end
    m_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (s_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_ready_full: cycle %0d got %b want 0000", k, s_ready_o); end
      clock_sources();
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== a || m_last_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold: cycle %0d got %b/%h/%b want 1/%h/0", k, m_valid_o, m_data_o, m_last_o, a);
      end
    end
    m_ready_i = 1'b1;
    #1;
    checks++; if (s_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_ready_drain: got %b want 0010", s_ready_o); end
    clock_sources();
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== b || m_last_o !== 1'b0) begin errors++; $display("FAIL bp_b: got %b/%h/%b want 1/%h/0", m_valid_o, m_data_o, m_last_o, b); end
    clock_sources();
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== c || m_last_o !== 1'b1) begin errors++; $display("FAIL bp_c: got %b/%h/%b want 1/%h/1", m_valid_o, m_data_o, m_last_o, c); end
    src_en = 4'b0000;
    drive_sources();
    clock_sources();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", m_valid_o); end
  endtask

  task automatic test_stall();
    apply_reset();
    plen = 4;
    src_en = 4'b0101;
    drive_sources();
    clock_sources();
    checks++; if (grant_o !== 2'd0 || busy_o !== 1'b1) begin errors++; $display("FAIL stall_grant: got %0d/%b want 0/1", grant_o, busy_o); end
    clock_sources();
    clock_sources();
    checks++; if (m_data_o !== beat_data(0, 1) || m_last_o !== 1'b0) begin errors++; $display("FAIL stall_beat1: got %h/%b want %h/0", m_data_o, m_last_o, beat_data(0, 1)); end
    src_en = 4'b0100;
    drive_sources();
    for (int k = 0; k < 3; k++) begin
      clock_sources();
      checks++;
      if (grant_o !== 2'd0 || busy_o !== 1'b1 || s_ready_o !== 4'b0001 || m_valid_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold: cycle %0d grant/busy/ready/valid got %0d/%b/%b/%b want 0/1/0001/0", k, grant_o, busy_o, s_ready_o, m_valid_o);
      end
    end
    src_en = 4'b0101;
    drive_sources();
    clock_sources();
    checks++; if (m_id_o !== 2'd0 || m_data_o !== beat_data(0, 2)) begin errors++; $display("FAIL stall_beat2: got %0d/%h want 0/%h", m_id_o, m_data_o, beat_data(0, 2)); end
    clock_sources();
    checks++; if (m_id_o !== 2'd0 || m_data_o !== beat_data(0, 3) || m_last_o !== 1'b1) begin errors++; $display("FAIL stall_beat3: got %0d/%h/%b want 0/%h/1", m_id_o, m_data_o, m_last_o, beat_data(0, 3)); end
    clock_sources();
    checks++; if (grant_o !== 2'd2 || busy_o !== 1'b1) begin errors++; $display("FAIL stall_next: got %0d/%b want 2/1", grant_o, busy_o); end
    clock_sources();
    checks++; if (m_valid_o !== 1'b1 || m_id_o !== 2'd2 || m_data_o !== beat_data(2, 0)) begin errors++; $display("FAIL stall_src2: got %b/%0d/%h want 1/2/%h", m_valid_o, m_id_o, m_data_o, beat_data(2, 0)); end
  endtask

  task automatic test_single_beat_upsize();
    int fill = 0;
    int got = 0;
    int cyc = 0;
    logic [2:0]    u_keep = 3'b000;
    logic [DW-1:0] u_lane0 = '0;
    apply_reset();
    plen = 1;
    src_en = 4'b0111;
    drive_sources();
    while (got < 3 && cyc < 40) begin
      clock_sources();
      cyc++;
      if (m_valid_o === 1'b1) begin
        u_keep = u_keep | (3'b001 << fill);
        if (fill == 0) u_lane0 = m_data_o;
        if (m_last_o || fill == 2) begin
          checks++;
          if (u_keep !== 3'b001 || m_last_o !== 1'b1 || m_id_o !== IW'(got) || u_lane0 !== beat_data(got, 0)) begin
            errors++; $display("FAIL up_word: #%0d keep/last/id/data got %b/%b/%0d/%h want 001/1/%0d/%h", got, u_keep, m_last_o, m_id_o, u_lane0, got, beat_data(got, 0));
          end
          got++;
          fill = 0;
          u_keep = 3'b000;
        end else begin
          fill++;
        end
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL up_timeout: words seen %0d want 3", got); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_fairness();
    test_wrap_skip();
    test_backpressure();
    test_stall();
    test_single_beat_upsize();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
